pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised N-stage pipeline register chain with valid bits for the MIPS core.
//  It replaces the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB control registers.
//  One unified control path provides: global hold (memory not ready), load-use bubble at a
//  configurable stage, per-stage flush, and stall/retire performance counters.
// PARAMETERS
//  WIDTH         32  payload bits per stage
//  STAGES        4   number of stages (>=2); stage 0 = IF/ID, stage STAGES-1 = MEM/WB
//  BUBBLE_STAGE  1   stage that receives the load-use bubble (1..STAGES-1)
//  CNT_W         32  width of the stall and retire counters
// PORTS
//  clk          in   1               clock, all state on rising edge
//  rst          in   1               synchronous, active-low reset
//  in_valid     in   1               fetch stage offers a payload
//  in_data      in   WIDTH           payload entering stage 0
//  in_ready     out  1               stage 0 loads in_data this cycle
//  hold         in   1               global freeze (driven by !mem_ready)
//  bubble       in   1               load-use hazard: insert bubble at BUBBLE_STAGE
//  flush_mask   in   STAGES          bit i forces the next valid of stage i to 0
//  cnt_clr      in   1               clear both counters
//  stage_valid  out  STAGES          valid bit of each stage
//  stage_data   out  STAGES*WIDTH    stage i occupies bits [i*WIDTH +: WIDTH]
//  retire_cnt   out  CNT_W           count of payloads that left the last stage
//  stall_cnt    out  CNT_W           count of cycles with hold or bubble asserted
// BEHAVIOUR
//  Reset (rst==0 at an edge):
//   - All stage_valid, stage_data and both counters are 0.
//   - in_ready is 0 while rst==0; reset overrides every other input.
//  Priority per edge: reset > hold > bubble > normal advance. flush_mask applies in all non-reset modes.
//  Normal (hold==0, bubble==0):
//   - stage0 <= {in_valid, in_data}; stage i <= stage i-1.
//   - in_ready = 1.
//   - Latency in->stage_data[STAGES-1] = STAGES edges.
//  Hold:
//   - All stage data and valids keep their values; in_ready = 0; bubble is ignored.
//  Bubble (hold==0):
//   - Stages 0..BUBBLE_STAGE-1 keep their values; stage BUBBLE_STAGE <= valid 0 (data 0).
//   - Stages above BUBBLE_STAGE advance normally; in_ready = 0.
//  Flush:
//   - After the mode above is applied, each stage i with flush_mask[i]=1 gets valid 0.
//   - Its data field still takes the value the mode selected (held or shifted).
//   - Flush during hold clears valids without moving data.
//  in_ready is combinational = rst & !hold & !bubble. in_data is ignored when in_ready==0.
//  Payload is not inspected; an invalid stage carries don't-care data except after reset (0).
//  Retire: retire_cnt += 1 at an edge where stage_valid[STAGES-1]==1 and hold==0.
//  Stall: stall_cnt += 1 at each edge with hold|bubble.
//  Counters:
//   - Both saturate at all-ones; no wrap.
//   - cnt_clr zeroes both counters on that edge and suppresses that cycle's increment.
//  Reset mid-operation discards all in-flight payloads; no partial state survives.
// TESTING  (STAGES=4, WIDTH=32, BUBBLE_STAGE=1, CNT_W=32 unless noted)
//  1. Reset, then push 0x11,0x22,0x33,0x44 on edges 1-4.
//     -> After edge 4: stage_data = {0x11,0x22,0x33,0x44}, stage 3 = 0x11, valid=4'b1111.
//     -> After edge 5: retire_cnt=1.
//  2. Full pipe, hold=1 for 3 edges.
//     -> Data and valid unchanged; in_ready=0 throughout; stall_cnt=3; retire_cnt unchanged.
//  3. stage0=A, stage1=B, stage2=C, bubble=1 for one edge.
//     -> stage0=A, stage1 invalid, stage2=B, stage3=C; in_ready=0 that cycle.
//  4. flush_mask=4'b0001, in_valid=1, in_data=0xDEAD, stage0=A.
//     -> stage0 valid=0, stage1=A valid.
//  5. hold=1 with flush_mask=4'b0011 on a full pipe.
//     -> Valid=4'b1100; all data unchanged; stall_cnt+1.
//  6. rst=0 for one edge on a full pipe.
//     -> Valid=0, data=0, counters=0.
//     -> Separately, with CNT_W=4 and 20 hold edges: stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: N-stage pipeline register chain with valid bits.
// A single control path covers global hold, a load-use bubble injected at
// BUBBLE_STAGE, per-stage flush, and saturating stall/retire counters.
module pipe_stage_chain #(
    parameter int WIDTH        = 32,
    parameter int STAGES       = 4,
    parameter int BUBBLE_STAGE = 1,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic                      hold,
    input  logic                      bubble,
    input  logic [STAGES-1:0]         flush_mask,
    input  logic                      cnt_clr,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic [CNT_W-1:0]          retire_cnt,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0]       valid_q, valid_nxt;
    logic [STAGES*WIDTH-1:0] data_q, data_nxt;
    logic [CNT_W-1:0]        retire_q, stall_q;
    logic                    retire_inc, stall_inc;

    // Stage 0 only accepts a new payload on a plain advance.
    assign in_ready = rst & ~hold & ~bubble;

    // A payload leaves the last stage whenever the chain is not frozen.
    assign retire_inc = valid_q[STAGES-1] & ~hold;
    assign stall_inc  = hold | bubble;

    // Next-state of the chain: hold > bubble > advance, then flush kills valids.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        valid_nxt = valid_q;
        data_nxt  = data_q;
        if (!hold) begin
            if (bubble) begin
                // Upper stages drain, lower stages stay put, bubble stage empties.
                for (int i = BUBBLE_STAGE + 1; i < STAGES; i++) begin
                    valid_nxt[i]               = valid_q[i-1];
                    data_nxt[i*WIDTH +: WIDTH] = data_q[(i-1)*WIDTH +: WIDTH];
                end
                valid_nxt[BUBBLE_STAGE]               = 1'b0;
                data_nxt[BUBBLE_STAGE*WIDTH +: WIDTH] = '0;
            end else begin
                for (int i = 1; i < STAGES; i++) begin
                    valid_nxt[i]               = valid_q[i-1];
                    data_nxt[i*WIDTH +: WIDTH] = data_q[(i-1)*WIDTH +: WIDTH];
                end
                valid_nxt[0]          = in_valid;
                data_nxt[0 +: WIDTH]  = in_data;
            end
        end
        // Flush only clears the valid; data still follows the selected mode.
        valid_nxt = valid_nxt & ~flush_mask;
    end

    // Stage registers; reset clears data too so nothing from before reset survives.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_nxt;
            data_q  <= data_nxt;
        end
    end

    // Saturating performance counters; clear wins over that cycle's increment.
    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            if (retire_inc && retire_q != CNT_MAX) retire_q <= retire_q + CNT_ONE;
            if (stall_inc && stall_q != CNT_MAX)   stall_q  <= stall_q + CNT_ONE;
        end
    end

    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign retire_cnt  = retire_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed scenarios plus randomized traffic, checked
// against an array-based behavioural model of the pipeline and counters.
module tb_pipe_stage_chain;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int BS = 1;

    logic            clk = 1'b0;
    logic            rst, in_valid, hold, bubble, cnt_clr;
    logic [W-1:0]    in_data;
    logic [S-1:0]    flush_mask;
    logic            in_ready, in_ready_s;
    logic [S-1:0]    stage_valid, stage_valid_s;
    logic [S*W-1:0]  stage_data, stage_data_s;
    logic [31:0]     retire_cnt, stall_cnt;
    logic [3:0]      retire_cnt_s, stall_cnt_s;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic         m_valid [S];
    logic [W-1:0] m_data  [S];
    longint       m_retire, m_stall, m_retire_s, m_stall_s;

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_STAGE(BS), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .hold(hold), .bubble(bubble),
        .flush_mask(flush_mask), .cnt_clr(cnt_clr),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance on the same stimulus, to exercise saturation.
    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_STAGE(BS), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .hold(hold), .bubble(bubble),
        .flush_mask(flush_mask), .cnt_clr(cnt_clr),
        .stage_valid(stage_valid_s), .stage_data(stage_data_s),
        .retire_cnt(retire_cnt_s), .stall_cnt(stall_cnt_s)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [S*W-1:0] pack_data();
        logic [S*W-1:0] v;
        for (int i = 0; i < S; i++) v[i*W +: W] = m_data[i];
        return v;
    endfunction

    function automatic logic [S-1:0] pack_valid();
        logic [S-1:0] v;
        for (int i = 0; i < S; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic longint sat_inc(input longint c, input longint max);
        return (c < max) ? c + 1 : c;
    endfunction

    // Apply one clock edge to the model using the behaviour rules directly.
    task automatic model_edge();
        logic ret;
        if (!rst) begin
            for (int i = 0; i < S; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
            end
            m_retire = 0; m_stall = 0; m_retire_s = 0; m_stall_s = 0;
            return;
        end
        ret = m_valid[S-1] && !hold;
        if (cnt_clr) begin
            m_retire = 0; m_stall = 0; m_retire_s = 0; m_stall_s = 0;
        end else begin
            if (ret) begin
                m_retire   = sat_inc(m_retire, 64'hFFFF_FFFF);
                m_retire_s = sat_inc(m_retire_s, 15);
            end
            if (hold || bubble) begin
                m_stall   = sat_inc(m_stall, 64'hFFFF_FFFF);
                m_stall_s = sat_inc(m_stall_s, 15);
            end
        end
        if (!hold) begin
            if (bubble) begin
                for (int i = S - 1; i > BS; i--) begin
                    m_valid[i] = m_valid[i-1];
                    m_data[i]  = m_data[i-1];
                end
                m_valid[BS] = 1'b0;
                m_data[BS]  = '0;
            end else begin
                for (int i = S - 1; i > 0; i--) begin
                    m_valid[i] = m_valid[i-1];
                    m_data[i]  = m_data[i-1];
                end
                m_valid[0] = in_valid;
                m_data[0]  = in_data;
            end
        end
        for (int i = 0; i < S; i++) if (flush_mask[i]) m_valid[i] = 1'b0;
    endtask

    // Drive one cycle, check in_ready before the edge and all state after it.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] id,
                        input logic h, input logic b, input logic [S-1:0] fm,
                        input logic clr);
        rst = r; in_valid = iv; in_data = id; hold = h; bubble = b;
        flush_mask = fm; cnt_clr = clr;
        #1;
        check("in_ready", in_ready, r & !h & !b);
        @(posedge clk);
        model_edge();
        #1;
        check("valid",      stage_valid,  pack_valid());
        check("data",       stage_data,   pack_data());
        check("retire",     retire_cnt,   m_retire);
        check("stall",      stall_cnt,    m_stall);
        check("retire_w4",  retire_cnt_s, m_retire_s);
        check("stall_w4",   stall_cnt_s,  m_stall_s);
    endtask

    task automatic fill(input logic [W-1:0] base);
        for (int i = 0; i < S; i++) step(1, 1, base + W'(i), 0, 0, '0, 0);
    endtask

    initial begin
        logic [S*W-1:0] snap;
        longint rsnap;
        rst = 0; in_valid = 0; in_data = '0; hold = 0; bubble = 0;
        flush_mask = '0; cnt_clr = 0;
        for (int i = 0; i < S; i++) begin m_valid[i] = 0; m_data[i] = '0; end
        m_retire = 0; m_stall = 0; m_retire_s = 0; m_stall_s = 0;

        // Reset state
        step(0, 1, 32'hFFFF, 0, 0, '0, 0);
        check("rst_valid", stage_valid, 4'b0000);
        check("rst_data",  stage_data,  128'h0);
        check("rst_ready_low", in_ready, 1'b0);

        // 1: push 0x11..0x44, latency and first retire
        step(1, 1, 32'h11, 0, 0, '0, 0);
        step(1, 1, 32'h22, 0, 0, '0, 0);
        step(1, 1, 32'h33, 0, 0, '0, 0);
        step(1, 1, 32'h44, 0, 0, '0, 0);
        check("t1_data",  stage_data,  {32'h11, 32'h22, 32'h33, 32'h44});
        check("t1_valid", stage_valid, 4'b1111);
        check("t1_retire0", retire_cnt, 32'd0);
        step(1, 1, 32'h55, 0, 0, '0, 0);
        check("t1_retire1", retire_cnt, 32'd1);

        // 2: hold on a full pipe for three edges
        snap  = stage_data;
        rsnap = m_retire;
        for (int i = 0; i < 3; i++) step(1, 1, 32'hBAD0 + i, 1, 0, '0, 0);
        check("t2_data",   stage_data, snap);
        check("t2_stall",  stall_cnt,  32'd3);
        check("t2_retire", retire_cnt, rsnap);

        // 3: bubble at stage 1 (stage0=A, stage1=B, stage2=C)
        fill(32'hA0);
        step(1, 1, 32'hEEEE, 0, 1, '0, 0);
        check("t3_valid", stage_valid, 4'b1101);
        check("t3_s2", stage_data[2*W +: W], 32'hA2);
        check("t3_s3", stage_data[3*W +: W], 32'hA1);
        check("t3_s0", stage_data[0 +: W],   32'hA3);

        // 4: flush stage 0 while loading 0xDEAD
        step(1, 1, 32'hDEAD, 0, 0, 4'b0001, 0);
        check("t4_valid01", stage_valid[1:0], 2'b10);
        check("t4_s1", stage_data[W +: W], 32'hA3);

        // 5: hold with flush on a full pipe
        fill(32'hC0);
        snap = stage_data;
        rsnap = m_stall;
        step(1, 0, '0, 1, 0, 4'b0011, 0);
        check("t5_valid", stage_valid, 4'b1100);
        check("t5_data",  stage_data,  snap);
        check("t5_stall", stall_cnt,   32'(rsnap + 1));

        // cnt_clr suppresses that cycle's increment
        step(1, 0, '0, 1, 0, '0, 1);
        check("clr_stall", stall_cnt, 32'd0);

        // 6: reset mid-operation, then narrow counter saturation
        fill(32'hD0);
        step(0, 1, 32'h1234, 1, 1, '1, 0);
        check("t6_valid", stage_valid, 4'b0000);
        check("t6_data",  stage_data,  128'h0);
        check("t6_cnt",   retire_cnt,  32'd0);
        for (int i = 0; i < 20; i++) step(1, 0, '0, 1, 0, '0, 0);
        check("t6_sat4",  stall_cnt_s, 4'd15);
        check("t6_stall32", stall_cnt, 32'd20);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 99) != 0),
                 1'($urandom),
                 W'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0) ? S'($urandom) : '0,
                 ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
